// File: rtl/tuse_hazard_ctrl_pkg.sv
// Shared definitions for the Tuse/Tnew hazard controller: instruction
// field positions, opcode/funct encodings, the Tuse "never" value, the
// shadow stage record and the D-stage forward select encoding.
// Build option: TUSE_STALL_STATS_EN enables the stall-cycle counter.
package tuse_hazard_ctrl_pkg;

   localparam int TNEW_W = 2;
   localparam int STAT_W = 32;

   // Field positions inside a 32-bit MIPS instruction
   localparam int OP_HI = 31;
   localparam int OP_LO = 26;
   localparam int RS_HI = 25;
   localparam int RS_LO = 21;
   localparam int RT_HI = 20;
   localparam int RT_LO = 16;
   localparam int FN_HI = 5;
   localparam int FN_LO = 0;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_SLTIU = 6'h0b;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_XORI  = 6'h0e;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   // R-type functs that read rs in D (register jumps)
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;

   // Tuse for an operand the instruction does not read: larger than any Tnew
   localparam logic [TNEW_W-1:0] TUSE_NEVER = 2'd3;

   // One pipeline stage as seen by the hazard logic
   typedef struct packed {
      logic [4:0]        wa;
      logic [TNEW_W-1:0] tnew;
   } stage_t;

   typedef enum logic [1:0] {
      SEL_GRF = 2'b00,
      SEL_E   = 2'b01,
      SEL_M   = 2'b10,
      SEL_W   = 2'b11
   } fwd_sel_e;

   // Remaining Tnew one stage later; saturates at zero
   function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction

   // Stage writes the register an operand reads (register 0 never matches)
   function automatic logic stage_match(input stage_t s, input logic [4:0] r);
      return (s.wa != 5'd0) && (s.wa == r);
   endfunction

   // Newest matching stage decides; a match still in flight blocks older ones
   function automatic fwd_sel_e fwd_select(input stage_t e, input stage_t m,
                                           input stage_t w, input logic [4:0] r);
      if (stage_match(e, r))      return (e.tnew == '0) ? SEL_E : SEL_GRF;
      else if (stage_match(m, r)) return (m.tnew == '0) ? SEL_M : SEL_GRF;
      else if (stage_match(w, r)) return (w.tnew == '0) ? SEL_W : SEL_GRF;
      else                        return SEL_GRF;
   endfunction

endpackage

// File: rtl/tuse_hazard_ctrl_if.sv
// Signal bundle between the pipeline (master) and the hazard controller
// (slave). No handshake: all signals are level-valued every cycle.
// Build option: TUSE_STALL_STATS_EN adds stall_cnt.
interface tuse_hazard_ctrl_if;
   import tuse_hazard_ctrl_pkg::*;

   logic [31:0]       d_inst;
   logic [4:0]        d_wa;
   logic [TNEW_W-1:0] d_tnew;
   logic              stall;
   logic [1:0]        fwd_rs_sel;
   logic [1:0]        fwd_rt_sel;
   logic [4:0]        e_wa;
   logic [4:0]        m_wa;
   logic [TNEW_W-1:0] e_tnew;
   logic [TNEW_W-1:0] m_tnew;
`ifdef TUSE_STALL_STATS_EN
   logic [STAT_W-1:0] stall_cnt;
`endif

   modport master (
`ifdef TUSE_STALL_STATS_EN
      input  stall_cnt,
`endif
      output d_inst, d_wa, d_tnew,
      input  stall, fwd_rs_sel, fwd_rt_sel, e_wa, m_wa, e_tnew, m_tnew
   );

   modport slave (
`ifdef TUSE_STALL_STATS_EN
      output stall_cnt,
`endif
      input  d_inst, d_wa, d_tnew,
      output stall, fwd_rs_sel, fwd_rt_sel, e_wa, m_wa, e_tnew, m_tnew
   );
endinterface

// File: rtl/tuse_hazard_ctrl_tuse_decoder.sv
// Tuse decoder: for the D-stage instruction, how many cycles until rs/rt
// are actually consumed. Operands not read get TUSE_NEVER.
module tuse_decoder
   import tuse_hazard_ctrl_pkg::*;
(
   input  logic [31:0]       inst_i,
   output logic [TNEW_W-1:0] tuse_rs_o,
   output logic [TNEW_W-1:0] tuse_rt_o
);

   logic [5:0] op;
   logic [5:0] fn;

   assign op = inst_i[OP_HI:OP_LO];
   assign fn = inst_i[FN_HI:FN_LO];

   // Opcode/funct to per-operand Tuse; the all-zero nop reads nothing
   always_comb begin
      tuse_rs_o = TUSE_NEVER;
      tuse_rt_o = TUSE_NEVER;
      if (inst_i != 32'd0) begin
         case (op)
            OP_RTYPE: begin
               if (fn == FN_JR || fn == FN_JALR) begin
                  tuse_rs_o = 2'd0;
               end else begin
                  tuse_rs_o = 2'd1;
                  tuse_rt_o = 2'd1;
               end
            end
            OP_BEQ, OP_BNE: begin
               tuse_rs_o = 2'd0;
               tuse_rt_o = 2'd0;
            end
            OP_LW, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI: begin
               tuse_rs_o = 2'd1;
            end
            OP_SW: begin
               tuse_rs_o = 2'd1;
               tuse_rt_o = 2'd2;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/tuse_hazard_ctrl.sv
// Tuse/Tnew hazard controller for a 5-stage MIPS pipeline. Shadows the
// destination register and remaining Tnew of E/M/W, raises stall when a
// D-stage operand is needed before its producer can supply it, and picks
// the D-stage forwarding source.
// Build option: TUSE_STALL_STATS_EN adds a wrapping stall-cycle counter.
module tuse_hazard_ctrl
   import tuse_hazard_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   tuse_hazard_ctrl_if.slave hif
);

   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [TNEW_W-1:0] tuse_rs;
   logic [TNEW_W-1:0] tuse_rt;
   stage_t            e_q, e_d, m_q, m_d, w_q, w_d;
   logic              stall;

   assign rs = hif.d_inst[RS_HI:RS_LO];
   assign rt = hif.d_inst[RT_HI:RT_LO];

   tuse_decoder u_tuse_decoder (
      .inst_i    (hif.d_inst),
      .tuse_rs_o (tuse_rs),
      .tuse_rt_o (tuse_rt)
   );

   // Stall when an E or M producer still needs more cycles than the consumer can wait
   always_comb begin
      stall = 1'b0;
      if (stage_match(e_q, rs) && e_q.tnew > tuse_rs) stall = 1'b1;
      if (stage_match(m_q, rs) && m_q.tnew > tuse_rs) stall = 1'b1;
      if (stage_match(e_q, rt) && e_q.tnew > tuse_rt) stall = 1'b1;
      if (stage_match(m_q, rt) && m_q.tnew > tuse_rt) stall = 1'b1;
   end

   // Next shadow contents: a stall injects a bubble into E
   always_comb begin
      e_d = stall ? '0 : '{wa: hif.d_wa, tnew: hif.d_tnew};
      m_d = '{wa: e_q.wa, tnew: sat_dec(e_q.tnew)};
      w_d = '{wa: m_q.wa, tnew: sat_dec(m_q.tnew)};
   end

   // Shadow stage registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else begin
         e_q <= e_d;
         m_q <= m_d;
         w_q <= w_d;
      end
   end

   assign hif.stall      = stall;
   assign hif.fwd_rs_sel = fwd_select(e_q, m_q, w_q, rs);
   assign hif.fwd_rt_sel = fwd_select(e_q, m_q, w_q, rt);
   assign hif.e_wa       = e_q.wa;
   assign hif.m_wa       = m_q.wa;
   assign hif.e_tnew     = e_q.tnew;
   assign hif.m_tnew     = m_q.tnew;

`ifdef TUSE_STALL_STATS_EN
   localparam logic [STAT_W-1:0] CNT_ONE = 1;
   logic [STAT_W-1:0] stall_cnt_q;

   // Count stalled cycles; wraps naturally
   always_ff @(posedge clk) begin
      if (!reset)     stall_cnt_q <= '0;
      else if (stall) stall_cnt_q <= stall_cnt_q + CNT_ONE;
   end

   assign hif.stall_cnt = stall_cnt_q;
`endif

endmodule
